// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: one shared micro-rotation step per cycle,
// ITERS steps per job, valid/ready on both sides.
module cordic_iter_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int ITERS = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          in_mode_i,
  input  logic [DW-1:0] in_x_i,
  input  logic [DW-1:0] in_y_i,
  input  logic [AW-1:0] in_a_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_x_o,
  output logic [DW-1:0] out_y_o,
  output logic [AW-1:0] out_a_o,
  output logic          busy_o
);

  localparam int MINW = (DW < AW) ? DW : AW;
  localparam int IW   = (ITERS > 1) ? $clog2(ITERS) : 1;

  if (ITERS < 1 || ITERS > MINW - 1) begin : g_bad_iters
    $error("cordic_iter_ctrl: ITERS out of range");
  end

  typedef logic [ITERS-1:0][AW-1:0] atan_tbl_t;

  // atan(2^-i) scaled so that 2^(AW-1) == pi, rounded to nearest
  function automatic atan_tbl_t build_atan();
    atan_tbl_t tbl;
    real       pi_r;
    real       scale;
    real       x;
    real       p;
    real       s;
    logic [AW-1:0] v;
    pi_r  = 3.14159265358979323846;
    scale = 1.0;
    tbl   = '0;
    for (int k = 0; k < AW - 1; k++) begin
      scale = scale * 2.0;
    end
    for (int i = ITERS - 1; i >= 0; i--) begin
      if (i == 0) begin
        s = pi_r / 4.0;
      end else begin
        x = 1.0;
        for (int k = 0; k < i; k++) begin
          x = x / 2.0;
        end
        p = x;
        s = 0.0;
        for (int k = 0; k < 40; k++) begin
          if ((k % 2) == 0) s = s + p / real'(2 * k + 1);
          else              s = s - p / real'(2 * k + 1);
          p = p * x * x;
        end
      end
      v   = AW'($rtoi(s / pi_r * scale + 0.5));
      tbl = atan_tbl_t'({tbl, v});
    end
    return tbl;
  endfunction

  localparam atan_tbl_t ATAN = build_atan();

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [IW-1:0]         iter_q;
  logic                  mode_q;
  logic signed [DW-1:0]  x_q;
  logic signed [DW-1:0]  y_q;
  logic signed [AW-1:0]  a_q;

  logic signed [DW-1:0]  xs;
  logic signed [DW-1:0]  ys;
  logic [AW-1:0]         t;
  logic                  d;
  logic                  ccw;
  logic signed [DW-1:0]  x_nx;
  logic signed [DW-1:0]  y_nx;
  logic signed [AW-1:0]  a_nx;
  logic                  last;

  assign xs   = x_q >>> iter_q;
  assign ys   = y_q >>> iter_q;
  assign t    = ATAN[iter_q];
  assign last = (iter_q == IW'(ITERS - 1));

  // d picks the angle direction; ccw picks the x/y rotation sense
  always_comb begin
    d    = 1'b0;
    ccw  = 1'b0;
    x_nx = x_q;
    y_nx = y_q;
    a_nx = a_q;
    unique case (1'b1)
      mode_q:  d = y_q[DW-1];
      default: d = a_q[AW-1];
    endcase
    ccw = mode_q ? d : ~d;
    if (ccw) begin
      x_nx = x_q - ys;
      y_nx = y_q + xs;
    end else begin
      x_nx = x_q + ys;
      y_nx = y_q - xs;
    end
    if (d) a_nx = a_q + $signed(t);
    else   a_nx = a_q - $signed(t);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      mode_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      a_q         <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            x_q        <= in_x_i;
            y_q        <= in_y_i;
            a_q        <= in_a_i;
            mode_q     <= in_mode_i;
            iter_q     <= '0;
            state_q    <= RUN;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        RUN: begin
          x_q <= x_nx;
          y_q <= y_nx;
          a_q <= a_nx;
          if (last) begin
            iter_q      <= '0;
            state_q     <= DONE;
            out_valid_o <= 1'b1;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  assign out_x_o = x_q;
  assign out_y_o = y_q;
  assign out_a_o = a_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: directed accuracy/timing cases plus
// randomized jobs against an integer CORDIC reference model.
module tb_cordic_iter_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int ITERS = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_y = '0;
  logic [AW-1:0] in_a = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_x;
  logic [DW-1:0] out_y;
  logic [AW-1:0] out_a;
  logic          busy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int acc_q[$];
  int hs_q[$];
  int atan_t[ITERS];

  cordic_iter_ctrl #(.DW(DW), .AW(AW), .ITERS(ITERS)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_mode_i  (in_mode),
    .in_x_i     (in_x),
    .in_y_i     (in_y),
    .in_a_i     (in_a),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_x_o    (out_x),
    .out_y_o    (out_y),
    .out_a_o    (out_a),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    if (out_valid && out_ready) hs_q.push_back(cyc);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp,
                           input int tol);
    nvec++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int atan_ref(input int i);
    real x;
    x = 1.0;
    for (int k = 0; k < i; k++) x = x / 2.0;
    return $rtoi($atan(x) / 3.14159265358979 * 32768.0 + 0.5);
  endfunction

  function automatic int wrap(input int v, input int w);
    return (v <<< (32 - w)) >>> (32 - w);
  endfunction

  // Plain-integer CORDIC: each step turns toward a->0 (rotation)
  // or toward y->0 (vectoring), accumulating the used angle.
  task automatic model(input bit m, input int x0, input int y0, input int a0,
                       output int xr, output int yr, output int ar);
    int x;
    int y;
    int a;
    int nx;
    int ny;
    bit toward_neg;
    x = x0;
    y = y0;
    a = a0;
    for (int i = 0; i < ITERS; i++) begin
      toward_neg = m ? (y >= 0) : (a < 0);
      if (toward_neg) begin
        nx = x + (y >>> i);
        ny = y - (x >>> i);
      end else begin
        nx = x - (y >>> i);
        ny = y + (x >>> i);
      end
      if (m) a = toward_neg ? a - atan_t[i] : a + atan_t[i];
      else   a = toward_neg ? a + atan_t[i] : a - atan_t[i];
      x = wrap(nx, DW);
      y = wrap(ny, DW);
      a = wrap(a, AW);
    end
    xr = x;
    yr = y;
    ar = a;
  endtask

  task automatic start_job(input string tag, input bit m, input int x0,
                           input int y0, input int a0);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 1);
    in_mode  = m;
    in_x     = DW'(x0);
    in_y     = DW'(y0);
    in_a     = AW'(a0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_mode  = ~m;
    in_x     = DW'($urandom);
    in_y     = DW'($urandom);
    in_a     = AW'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, ITERS);
  endtask

  task automatic run_job(input string tag, input bit m, input int x0,
                         input int y0, input int a0,
                         output int xr, output int yr, output int ar);
    int ex;
    int ey;
    int ea;
    start_job(tag, m, x0, y0, a0);
    check({tag, "_busy"}, 32'(busy), 1);
    wait_valid(tag);
    model(m, x0, y0, a0, ex, ey, ea);
    xr = $signed(out_x);
    yr = $signed(out_y);
    ar = $signed(out_a);
    check({tag, "_x"}, $signed(out_x), ex);
    check({tag, "_y"}, $signed(out_y), ey);
    check({tag, "_a"}, $signed(out_a), ea);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 0);
  endtask

  initial begin
    int rx;
    int ry;
    int ra;
    int b;
    int n;
    int bx;
    int by;
    int ba;
    int ex;
    int ey;
    int ea;
    bit m;
    for (int i = 0; i < ITERS; i++) atan_t[i] = atan_ref(i);

    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_x", $signed(out_x), 0);
    check("rst_y", $signed(out_y), 0);
    check("rst_a", $signed(out_a), 0);
    rst_n = 1'b1;
    tick();

    run_job("rot45", 1'b0, 19898, 0, 8192, rx, ry, ra);
    check_tol("rot45_xr", rx, 23170, 16);
    check_tol("rot45_yr", ry, 23170, 16);
    check_tol("rot45_ar", ra, 0, atan_t[ITERS-1]);

    run_job("vec", 1'b1, 10000, 10000, 0, rx, ry, ra);
    check_tol("vec_xr", rx, 23290, 16);
    check_tol("vec_yr", ry, 0, 16);
    check_tol("vec_ar", ra, -8192, atan_t[ITERS-1] + 4);

    run_job("rotneg", 1'b0, 10000, 0, -16384, rx, ry, ra);
    check_tol("rotneg_xr", rx, 0, 16);
    check_tol("rotneg_yr", ry, -16468, 16);

    // back-to-back timing with in_valid and out_ready held high
    b = acc_q.size();
    in_mode = 1'b0;
    in_x = 16'd1000;
    in_y = 16'd0;
    in_a = 16'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (hs_q.size() < b + 2 && n < 200) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("tim_jobs", hs_q.size() - b, 2);
    if (hs_q.size() >= b + 2 && acc_q.size() >= b + 2) begin
      check("tim_period", acc_q[b+1] - acc_q[b], ITERS + 2);
      check("tim_done1", hs_q[b] - acc_q[b], ITERS + 1);
      check("tim_done2", hs_q[b+1] - acc_q[b+1], ITERS + 1);
    end
    tick();

    // backpressure: results held, requests ignored
    b = acc_q.size();
    start_job("bp", 1'b1, 7000, -3000, 100);
    wait_valid("bp");
    bx = $signed(out_x);
    by = $signed(out_y);
    ba = $signed(out_a);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom);
      in_x = DW'($urandom);
      tick();
      check("bp_x", $signed(out_x), bx);
      check("bp_y", $signed(out_y), by);
      check("bp_a", $signed(out_a), ba);
      check("bp_rdy", 32'(in_ready), 0);
      check("bp_vld", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    model(1'b1, 7000, -3000, 100, ex, ey, ea);
    check("bp_mx", bx, ex);
    check("bp_my", by, ey);
    check("bp_ma", ba, ea);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("bp_accepts", acc_q.size() - b, 1);
    check("bp_idle_vld", 32'(out_valid), 0);
    check("bp_idle_rdy", 32'(in_ready), 1);

    // reset during RUN discards the job immediately
    b = hs_q.size();
    start_job("rr", 1'b0, 5000, 5000, 3000);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("rr_rdy", 32'(in_ready), 1);
    check("rr_vld", 32'(out_valid), 0);
    check("rr_busy", 32'(busy), 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("rr_nohs", hs_q.size() - b, 0);
    run_job("rr_next", 1'b0, 12000, -4000, -5000, rx, ry, ra);

    for (int j = 0; j < 24; j++) begin
      m = 1'($urandom);
      if (m)
        run_job("rnd_vec", 1'b1, int'($urandom_range(1, 9000)),
                int'($urandom_range(0, 18000)) - 9000,
                wrap(int'($urandom), AW), rx, ry, ra);
      else
        run_job("rnd_rot", 1'b0, int'($urandom_range(0, 18000)) - 9000,
                int'($urandom_range(0, 18000)) - 9000,
                wrap(int'($urandom), AW), rx, ry, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
